// File: rtl/addsub_sequencer.sv
// addsub_sequencer: LOAD/ADD/SUB/CLR command sequencer driving an external 8-bit adder/subtractor.
// Define ADDSUB_SEQ_SATURATE_EN for unsigned saturation on the ADD/SUB result capture.
module addsub_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [7:0] as_a,
    output logic [7:0] as_b,
    output logic       as_op,
    input  logic [7:0] as_sum,
    input  logic       as_cout,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_carry,
    output logic       res_zero,
    output logic       res_ovf
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t     state_q;
    logic [7:0] acc_q, operand_q, acc_d;
    logic       op_q, carry_q, ovf_q, ovf_d;
    assign cmd_ready = (state_q == IDLE) && !rst;
    assign res_valid = (state_q == DONE);
    assign res_data  = acc_q;
    assign res_carry = carry_q;
    assign res_ovf   = ovf_q;
    assign res_zero  = (acc_q == 8'h00);
    assign as_a      = acc_q;
    assign as_b      = operand_q;
    assign as_op     = op_q;
    // SUB overflows when operand signs differ; ADD when they match; both need the result sign to flip.
    assign ovf_d = ((acc_q[7] ^ operand_q[7]) == op_q) && (as_sum[7] != acc_q[7]);
`ifdef ADDSUB_SEQ_SATURATE_EN
    assign acc_d = as_cout ? (op_q ? 8'h00 : 8'hFF) : as_sum;
`else
    assign acc_d = as_sum;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= 8'h00;
            operand_q <= 8'h00;
            op_q      <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    if (cmd_op[1] ^ cmd_op[0]) begin
                        operand_q <= cmd_data;
                        op_q      <= cmd_op[1];
                        state_q   <= EXEC;
                    end else begin
                        acc_q   <= cmd_op[1] ? 8'h00 : cmd_data;
                        carry_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                EXEC: begin
                    acc_q   <= acc_d;
                    carry_q <= as_cout;
                    ovf_q   <= ovf_d;
                    state_q <= DONE;
                end
                DONE: if (res_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_sequencer.sv
// tb_addsub_sequencer: directed test of addsub_sequencer with a behavioural adder/subtractor.
module tb_addsub_sequencer;
    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_ready, as_op, as_cout, res_valid, res_ready;
    logic       res_carry, res_zero, res_ovf;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data, as_a, as_b, as_sum, res_data;
    logic [8:0] r;
    int         total = 0;
    int         bad = 0;

    addsub_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .as_a(as_a), .as_b(as_b), .as_op(as_op),
        .as_sum(as_sum), .as_cout(as_cout), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero), .res_ovf(res_ovf)
    );

    always #5 clk = ~clk;

    // External stage: Cout is carry-out for ADD and borrow for SUB.
    always_comb r = as_op ? {1'b0, as_a} - {1'b0, as_b} : {1'b0, as_a} + {1'b0, as_b};
    assign {as_cout, as_sum} = r;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic flags(input string tag, input logic [7:0] d, input logic c, input logic v, input logic z);
        chk({tag, "_data"}, res_data, d);
        chk({tag, "_carry"}, {7'b0, res_carry}, {7'b0, c});
        chk({tag, "_ovf"}, {7'b0, res_ovf}, {7'b0, v});
        chk({tag, "_zero"}, {7'b0, res_zero}, {7'b0, z});
    endtask

    // Issue one command from IDLE and return at the negedge where DONE is first visible.
    task automatic issue(input logic [1:0] op, input logic [7:0] d);
        for (int i = 0; i < 10 && !cmd_ready; i++) @(negedge clk);
        chk("ready_wait", {7'b0, cmd_ready}, 8'h01);
        cmd_op = op;
        cmd_data = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (op == 2'b01 || op == 2'b10) begin
            chk("exec_novalid", {7'b0, res_valid}, 8'h00);
            chk("exec_op", {7'b0, as_op}, {7'b0, op[1]});
            chk("exec_b", as_b, d);
            @(negedge clk);
        end
        chk("done_valid", {7'b0, res_valid}, 8'h01);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", {7'b0, res_valid}, 8'h00);
        chk("rst_data", res_data, 8'h00);
        chk("rst_zero", {7'b0, res_zero}, 8'h01);
        chk("rst_ready_forced", {7'b0, cmd_ready}, 8'h00);
        chk("rst_op", {7'b0, as_op}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", {7'b0, cmd_ready}, 8'h01);

        issue(2'b00, 8'h05);
        flags("load05", 8'h05, 1'b0, 1'b0, 1'b0);
        issue(2'b10, 8'h07);
`ifdef ADDSUB_SEQ_SATURATE_EN
        flags("borrow", 8'h00, 1'b1, 1'b0, 1'b1);
`else
        flags("borrow", 8'hFE, 1'b1, 1'b0, 1'b0);
`endif
        issue(2'b00, 8'h7F);
        issue(2'b01, 8'h01);
        flags("addovf", 8'h80, 1'b0, 1'b1, 1'b0);
        issue(2'b00, 8'h80);
        issue(2'b10, 8'h01);
        flags("subovf", 8'h7F, 1'b0, 1'b1, 1'b0);
        issue(2'b00, 8'hFF);
        issue(2'b01, 8'h01);
`ifdef ADDSUB_SEQ_SATURATE_EN
        flags("wrap", 8'hFF, 1'b1, 1'b0, 1'b0);
`else
        flags("wrap", 8'h00, 1'b1, 1'b0, 1'b1);
`endif
        issue(2'b11, 8'hAA);
        flags("clr", 8'h00, 1'b0, 1'b0, 1'b1);

        issue(2'b00, 8'h20);
        @(negedge clk);
        res_ready = 1'b0;
        issue(2'b01, 8'h10);
        cmd_op = 2'b00; cmd_data = 8'h55; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {7'b0, res_valid}, 8'h01);
            chk("bp_data", res_data, 8'h30);
            chk("bp_ready", {7'b0, cmd_ready}, 8'h00);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid", {7'b0, res_valid}, 8'h00);
        chk("bp_rel_ready", {7'b0, cmd_ready}, 8'h01);
        chk("bp_rel_data", res_data, 8'h30);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_next_valid", {7'b0, res_valid}, 8'h01);
        chk("bp_next_data", res_data, 8'h55);

        issue(2'b00, 8'h04);
        @(negedge clk);
        cmd_op = 2'b01; cmd_data = 8'h03; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rexec_in_exec", {7'b0, as_op}, 8'h00);
        chk("rexec_b", as_b, 8'h03);
        rst = 1'b1;
        @(negedge clk);
        chk("rexec_valid1", {7'b0, res_valid}, 8'h00);
        chk("rexec_data", res_data, 8'h00);
        chk("rexec_zero", {7'b0, res_zero}, 8'h01);
        @(negedge clk);
        chk("rexec_valid2", {7'b0, res_valid}, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("rexec_idle", {7'b0, cmd_ready}, 8'h01);
        chk("rexec_valid3", {7'b0, res_valid}, 8'h00);
        chk("rexec_acc", res_data, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/addsub_sequencer.md
# addsub_sequencer

Command-driven accumulator controller that sits directly upstream of the 8-bit adder/subtractor stage. It accepts LOAD/ADD/SUB/CLR commands over a valid/ready handshake and drives the stage's A, B and Op inputs. It captures the stage's Sum and Cout back into an 8-bit accumulator, then presents the result and flags downstream over a second valid/ready handshake. The adder/subtractor is instantiated outside this block; this block only drives and samples its ports.

## Interface
- No parameters; datapath width is fixed at 8 to match the adder/subtractor stage.

- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR
- cmd_data  in  8  operand (ignored for CLR)
- as_a  out  8  to adder A; always equals accumulator
- as_b  out  8  to adder B; registered operand
- as_op  out  1  to adder Op; 1 = subtract
- as_sum  in  8  from adder Sum
- as_cout  in  1  from adder Cout; 1 = carry-out (ADD) or borrow (SUB)
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  8  accumulator value
- res_carry  out  1  carry/borrow of last ADD/SUB
- res_zero  out  1  res_data == 0
- res_ovf  out  1  signed (two's-complement) overflow of last ADD/SUB

## Operation
- FSM states:
  - IDLE: cmd_ready = 1 (forced 0 while rst is high).
  - EXEC: adder inputs stable, sum sampled.
  - DONE: res_valid = 1.
- IDLE to EXEC: on an accepted ADD or SUB. Register operand_reg <= cmd_data and op_reg <= cmd_op[1].
- IDLE to DONE: on an accepted command of the other two types.
  - LOAD: acc <= cmd_data.
  - CLR: acc <= 0.
  - Both set carry = 0 and ovf = 0.
- EXEC to DONE: unconditional after one cycle. acc <= as_sum and carry <= as_cout.
  - ovf for ADD: (a7 == b7) & (s7 != a7).
  - ovf for SUB: (a7 != b7) & (s7 != a7).
  - Here a = acc before the update, b = operand_reg, s = as_sum.
- DONE to IDLE: when res_ready = 1.
- res_zero is derived combinationally from acc.
- as_a = acc, as_b = operand_reg, as_op = op_reg at all times. Only the EXEC-cycle sample is architecturally used.
- Arithmetic is modulo 256. Carry is the adder's raw Cout, with no inversion in this block.
- Commands offered outside IDLE are not accepted. The source must hold them.

## Timing
- Reset (synchronous): state = IDLE; acc, operand_reg, op_reg, carry and ovf all = 0. Therefore res_valid = 0, res_data = 0x00, res_zero = 1, as_op = 0.
- ADD/SUB latency: accepted in cycle N, EXEC in N+1, res_valid high from N+2.
- LOAD/CLR latency: accepted in cycle N, res_valid high from N+1.
- Throughput:
  - One ADD/SUB per 3 cycles with res_ready tied high.
  - One LOAD/CLR per 2 cycles with res_ready tied high.
- Backpressure: with res_ready low, DONE holds indefinitely. res_data and the flags stay stable and cmd_ready stays 0.
- Reset asserted during EXEC or DONE: aborts the operation, returns to reset state on the next edge, and drops any pending result.
- No combinational path from cmd_valid to cmd_ready, or from res_ready to res_valid.

## Configuration
- ADDSUB_SEQ_SATURATE_EN defined: unsigned saturation applied on the EXEC capture.
  - ADD with as_cout = 1 stores acc = 0xFF.
  - SUB with as_cout = 1 (borrow) stores acc = 0x00.
  - res_carry and res_ovf still report the raw adder result.
  - res_zero follows the saturated acc.
- Macro undefined: wrap-around (modulo 256) arithmetic; the saturation logic is absent.

## Test plan
- Reset: assert rst 2 cycles mid-stream, then release. Required:
  - res_valid = 0, res_data = 0x00, res_zero = 1, cmd_ready = 1.
  - Exactly one cycle after release, IDLE is reached.
- Borrow case: LOAD 0x05, then SUB 0x07. Required:
  - res_data = 0xFE, carry = 1, ovf = 0, zero = 0.
  - With SATURATE_EN: res_data = 0x00, zero = 1.
  - res_valid rises 2 cycles after SUB acceptance.
- Signed overflow: LOAD 0x7F, then ADD 0x01 gives res_data = 0x80, carry = 0, ovf = 1. LOAD 0x80, then SUB 0x01 gives 0x7F, carry = 0, ovf = 1.
- Carry wrap: LOAD 0xFF, then ADD 0x01. Required:
  - res_data = 0x00, carry = 1, zero = 1.
  - With SATURATE_EN: 0xFF, zero = 0.
- Backpressure: hold res_ready low 5 cycles after an ADD 0x10 with acc starting at 0x20. Required:
  - res_valid held high, res_data = 0x30 stable, cmd_ready = 0.
  - A concurrently offered command is not accepted until the cycle after res_ready rises.
- Reset in EXEC: accept ADD 0x03 with acc = 0x04, then assert rst in the EXEC cycle. Required: no res_valid pulse, acc = 0x00.
